// File: rtl/clmul_unit.sv
// Iterative carry-less multiplier (CLMUL/CLMULH/CLMULR) that consumes BITS_PER_CYCLE
// multiplier bits per cycle and finishes as soon as no set bits remain in operand B.
module clmul_unit #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 8,
  parameter int TRANS_ID_BITS  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               operation_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic [XLEN-1:0]          result_o,
  output logic                     result_valid_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
  input  logic                     result_ready_i
);

  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state;
  logic [PW-1:0]            acc;
  logic [PW-1:0]            a_sh;
  logic [XLEN-1:0]          b_sh;
  logic [1:0]               op;
  logic [TRANS_ID_BITS-1:0] tid;

  logic [PW-1:0]            acc_next;
  logic [XLEN-1:0]          b_next;

  function automatic logic [PW-1:0] chunk_product(input logic [PW-1:0] a,
                                                  input logic [BITS_PER_CYCLE-1:0] b);
    logic [PW-1:0] p;
    p = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b[j]) p = p ^ (a << j);
    end
    return p;
  endfunction

  // Opcode 11 is reserved and behaves as CLMUL.
  function automatic logic [XLEN-1:0] select_result(input logic [PW-1:0] p,
                                                    input logic [1:0]    sel);
    logic [XLEN-1:0] r;
    case (sel)
      2'b01:   r = p[PW-1:XLEN];
      2'b10:   r = p[PW-2:XLEN-1];
      default: r = p[XLEN-1:0];
    endcase
    return r;
  endfunction

  always_comb begin
    acc_next = acc ^ chunk_product(a_sh, b_sh[BITS_PER_CYCLE-1:0]);
    b_next   = b_sh >> BITS_PER_CYCLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      op    <= '0;
      tid   <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            op    <= operation_i;
            tid   <= trans_id_i;
            acc   <= '0;
            a_sh  <= {{XLEN{1'b0}}, operand_a_i};
            b_sh  <= operand_b_i;
            state <= (operand_b_i == '0) ? DONE : BUSY;
          end
        end
        // Early exit as soon as the remaining multiplier bits are all zero.
        BUSY: begin
          acc   <= acc_next;
          a_sh  <= a_sh << BITS_PER_CYCLE;
          b_sh  <= b_next;
          if (b_next == '0) state <= DONE;
        end
        DONE: begin
          if (result_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o           = (state == IDLE);
    result_valid_o    = (state == DONE);
    result_o          = result_valid_o ? select_result(acc, op) : '0;
    result_trans_id_o = result_valid_o ? tid : '0;
  end

endmodule

// File: doc/clmul_unit.md
# clmul_unit

Iterative carry-less multiply unit for the Zbc extension (CLMUL, CLMULH, CLMULR), parametrised in XLEN and bits-per-cycle. It sits beside the single-cycle ALU in the execute stage as a multi-cycle functional unit, with an issue-side valid/ready handshake, a writeback-side valid/ready handshake and flush support. Latency depends on the data: the unit stops early once no set bits remain in operand B.

## Interface
- XLEN, 64, operand/result width; 32 or 64.
- BITS_PER_CYCLE, 8, multiplier bits consumed per BUSY cycle; power of two, divides XLEN.
- TRANS_ID_BITS, 3, width of the scoreboard transaction id.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- flush_i  in  1  synchronous kill of any in-flight or completed operation.
- valid_i  in  1  issue request.
- ready_o  out  1  unit can accept; high only in IDLE.
- operation_i  in  2  00 CLMUL, 01 CLMULH, 10 CLMULR, 11 treated as CLMUL.
- operand_a_i  in  XLEN  rs1.
- operand_b_i  in  XLEN  rs2 (multiplier).
- trans_id_i  in  TRANS_ID_BITS  scoreboard id.
- result_o  out  XLEN  result; 0 when result_valid_o is low.
- result_valid_o  out  1  result available.
- result_trans_id_o  out  TRANS_ID_BITS  id of result; 0 when result_valid_o is low.
- result_ready_i  in  1  writeback accepts the result.

## Operation
- Full product P[2·XLEN-1:0] = XOR over i of (A << i) for each i where B[i]=1.
- Result selection: CLMUL = P[XLEN-1:0]. CLMULH = P[2·XLEN-1:XLEN]. CLMULR = P[2·XLEN-2:XLEN-1].
- Registers: acc (2·XLEN), a_sh (2·XLEN), b_sh (XLEN), op, trans_id.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Accept when valid_i & ready_o & ~flush_i: latch op and trans_id, acc=0, a_sh={0,A}, b_sh=B.
  - If B==0, go to DONE; otherwise go to BUSY.
- BUSY, per cycle:
  - acc ^= XOR over j<BITS_PER_CYCLE of (b_sh[j] ? a_sh<<j : 0).
  - a_sh <<= BITS_PER_CYCLE; b_sh >>= BITS_PER_CYCLE.
  - If the shifted b_sh is zero, go to DONE; otherwise stay in BUSY.
  - At most XLEN/BITS_PER_CYCLE BUSY cycles.
- DONE:
  - result_valid_o=1; result_o is selected combinationally from acc and op.
  - Leave to IDLE on result_ready_i. Outputs stay stable until then.
- No accept in DONE or BUSY; valid_i is ignored there.
- flush_i in any state: next state IDLE, the result is discarded, and the next cycle is acceptable. flush_i wins over a same-cycle accept and over a same-cycle result_ready_i. A flushed result is never presented.
- Reset takes priority over flush_i. State goes to IDLE and all registers clear.

## Timing
- Reset values: ready_o=1 (IDLE), result_valid_o=0, result_o=0, result_trans_id_o=0.
- Let valid_i be accepted in cycle c, and let k = index of the highest BITS_PER_CYCLE chunk of B that contains a set bit, plus 1 (k=0 for B=0).
- result_valid_o rises in cycle c+1+k.
  - Minimum latency: 1, for B=0.
  - Maximum latency: 1+XLEN/BITS_PER_CYCLE (9 for 64/8).
- ready_o is low from c+1 until the cycle after the result handshake. Sustained throughput is one operation per latency+1 cycles.
- Reset asserted mid-BUSY or in DONE: IDLE at the next edge, no result issued.
- XLEN=32 uses identical rules with 32-bit operands.

## Test plan
- Reset: hold rst_i for 2 cycles with valid_i=1 -> ready_o=1, result_valid_o=0, result_o=0, result_trans_id_o=0. Nothing is accepted during reset.
- Short multiplier (64/8): CLMUL, A=0x3, B=0x3, id=5, accepted in cycle c -> result_valid_o in c+2, result_o=0x5, result_trans_id_o=5. The same operands with CLMULH -> 0x0.
- Full latency (64/8): A=0xFFFF_FFFF_FFFF_FFFF, B=0x8000_0000_0000_0000 -> valid in c+9.
  - CLMUL = 0x8000_0000_0000_0000.
  - CLMULH = 0x7FFF_FFFF_FFFF_FFFF.
  - CLMULR = 0xFFFF_FFFF_FFFF_FFFF.
- Zero skip: B=0, A=0x1234, id=2 -> result_valid_o in c+1, result_o=0, id=2.
- Backpressure: complete an operation, then hold result_ready_i=0 for 5 cycles while driving valid_i=1 -> result_o and result_trans_id_o are constant, ready_o=0, no new accept. Raising result_ready_i gives IDLE the next cycle.
- Flush mid-BUSY: flush_i in the 3rd BUSY cycle -> ready_o=1 next cycle, result_valid_o never asserts for the killed id. A new CLMUL A=0x5, B=0x7 then completes with 0x1B.
